// File: rtl/conv2d_stream.sv
// Streaming KxK signed convolution over a raster pixel stream with line buffers and stride.
// Optional build macro CONV_RELU_EN clamps negative results to zero before res_out.
module conv2d_stream #(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int FILTER_SIZE  = 3,
    parameter int STRIDE       = 1,
    parameter int PIXEL_W      = 8,
    parameter int COEF_W       = 8,
    localparam int K           = FILTER_SIZE,
    localparam int ACC_W       = PIXEL_W + COEF_W + 1 + $clog2(FILTER_SIZE * FILTER_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [K*K*COEF_W-1:0]   filter,
    input  logic [PIXEL_W-1:0]      pix_in,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    output logic [ACC_W-1:0]        res_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    res_last,
    output logic                    busy,
    output logic                    done
);
    localparam int OUT_W   = (IMAGE_WIDTH - K) / STRIDE + 1;
    localparam int OUT_H   = (IMAGE_HEIGHT - K) / STRIDE + 1;
    localparam int NRES    = OUT_W * OUT_H;
    localparam int COL_W   = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int ROW_W   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int PH_W    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int RC_W    = $clog2(NRES + 1);
    localparam int PROD_W  = PIXEL_W + 1 + COEF_W;
    localparam int LB_ROWS = (K > 1) ? K - 1 : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_KM1  = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_KM1  = ROW_W'(K - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(STRIDE - 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(NRES - 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t                    state;
    logic [COEF_W-1:0]         coef [K*K];
    logic [PIXEL_W-1:0]        win [K][K];
    logic [PIXEL_W-1:0]        win_next [K][K];
    logic [PIXEL_W-1:0]        new_col [K];
    logic [PIXEL_W-1:0]        lb [LB_ROWS][IMAGE_WIDTH];
    logic [COL_W-1:0]          col;
    logic [ROW_W-1:0]          row;
    logic [PH_W-1:0]           col_ph;
    logic [PH_W-1:0]           row_ph;
    logic [RC_W-1:0]           res_cnt;
    logic                      xfer;
    logic                      win_ok;
    logic                      last_px;
    logic signed [PROD_W-1:0]  px_s;
    logic signed [PROD_W-1:0]  cf_s;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]          res_val;

    assign pix_ready = (state == STREAM) && (!res_valid || res_ready);
    assign xfer      = pix_valid && pix_ready;
    assign win_ok    = (row >= ROW_KM1) && (col >= COL_KM1) && (row_ph == '0) && (col_ph == '0);
    assign last_px   = (row == ROW_LAST) && (col == COL_LAST);

    // Row 0 of the window is the oldest image row; the incoming pixel fills the bottom row.
    always_comb begin
        for (int r = 0; r < K; r++) new_col[r] = pix_in;
        for (int r = 0; r < K - 1; r++) new_col[r] = lb[K-2-r][col];
        for (int r = 0; r < K; r++) begin
            for (int j = 0; j < K - 1; j++) win_next[r][j] = win[r][j+1];
            win_next[r][K-1] = new_col[r];
        end
    end

    always_comb begin
        acc  = '0;
        px_s = '0;
        cf_s = '0;
        prod = '0;
        for (int r = 0; r < K; r++) begin
            for (int j = 0; j < K; j++) begin
                px_s = PROD_W'($signed({1'b0, win_next[r][j]}));
                cf_s = PROD_W'($signed(coef[r*K+j]));
                prod = px_s * cf_s;
                acc  = acc + ACC_W'(prod);
            end
        end
`ifdef CONV_RELU_EN
        res_val = acc[ACC_W-1] ? '0 : acc;
`else
        res_val = acc;
`endif
    end

    // Storage that is always rewritten before it feeds a valid window needs no reset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            for (int r = 0; r < K; r++) begin
                for (int j = 0; j < K; j++) win[r][j] <= win_next[r][j];
            end
        end
    end

    generate
        if (K > 1) begin : g_lb
            always_ff @(posedge clk) begin
                if (xfer) begin
                    lb[0][col] <= pix_in;
                    for (int i = 1; i < K - 1; i++) lb[i][col] <= lb[i-1][col];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            col_ph    <= '0;
            row_ph    <= '0;
            res_cnt   <= '0;
            res_out   <= '0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < K * K; i++) coef[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < K * K; i++) coef[i] <= filter[i*COEF_W +: COEF_W];
                        col     <= '0;
                        row     <= '0;
                        col_ph  <= '0;
                        row_ph  <= '0;
                        res_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (col == COL_LAST) begin
                            col    <= '0;
                            col_ph <= '0;
                            row    <= row + 1'b1;
                            if (row < ROW_KM1)        row_ph <= '0;
                            else if (row_ph == PH_LAST) row_ph <= '0;
                            else                      row_ph <= row_ph + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                            if (col < COL_KM1)        col_ph <= '0;
                            else if (col_ph == PH_LAST) col_ph <= '0;
                            else                      col_ph <= col_ph + 1'b1;
                        end
                    end
                    if (xfer && win_ok) begin
                        res_out   <= res_val;
                        res_valid <= 1'b1;
                        res_last  <= (res_cnt == RC_LAST);
                        res_cnt   <= res_cnt + 1'b1;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        res_last  <= 1'b0;
                    end
                    // A last pixel that produces no result can finish at once if the output is empty.
                    if (xfer && last_px) begin
                        if (!win_ok && (!res_valid || res_ready)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (!res_valid || res_ready) begin
                        res_valid <= 1'b0;
                        res_last  <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream on a 5x5 frame, K=3, pixels 1..25, strides 1 and 2.
module tb_conv2d_stream;
    localparam int W     = 5;
    localparam int H     = 5;
    localparam int K     = 3;
    localparam int ACC_W = 21;
    localparam int FW    = K * K * 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           start1 = 1'b0, pv1 = 1'b0, rr1 = 1'b1;
    logic [FW-1:0]  filt1 = '0;
    logic [7:0]     pix1 = '0;
    logic           pr1, rv1, rl1, busy1, done1;
    logic [ACC_W-1:0] res1;

    logic           start2 = 1'b0, pv2 = 1'b0, rr2 = 1'b1;
    logic [FW-1:0]  filt2 = '0;
    logic [7:0]     pix2 = '0;
    logic           pr2, rv2, rl2, busy2, done2;
    logic [ACC_W-1:0] res2;

    conv2d_stream #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FILTER_SIZE(K), .STRIDE(1),
                    .PIXEL_W(8), .COEF_W(8)) u_s1 (
        .clk(clk), .rst(rst_n), .start(start1), .filter(filt1), .pix_in(pix1),
        .pix_valid(pv1), .pix_ready(pr1), .res_out(res1), .res_valid(rv1),
        .res_ready(rr1), .res_last(rl1), .busy(busy1), .done(done1));

    conv2d_stream #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FILTER_SIZE(K), .STRIDE(2),
                    .PIXEL_W(8), .COEF_W(8)) u_s2 (
        .clk(clk), .rst(rst_n), .start(start2), .filter(filt2), .pix_in(pix2),
        .pix_valid(pv2), .pix_ready(pr2), .res_out(res2), .res_valid(rv2),
        .res_ready(rr2), .res_last(rl2), .busy(busy2), .done(done2));

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int last_cyc1 = -1;
    int done_cyc1 = -1;
    logic [ACC_W-1:0] q1[$], q2[$];
    logic             l1[$], l2[$];

    localparam logic [FW-1:0] F_ONES = {9{8'h01}};
    localparam logic [FW-1:0] F_NEG  = {9{8'hFF}};
    localparam logic [FW-1:0] F_TWOS = {9{8'h02}};
    localparam logic [FW-1:0] F_HOT0 = {{8{8'h00}}, 8'h01};

    int e_s1[9]  = '{63, 72, 81, 108, 117, 126, 153, 162, 171};
    int e_s2[9]  = '{63, 81, 153, 171, 0, 0, 0, 0, 0};
    int e_hot[9] = '{1, 2, 3, 6, 7, 8, 11, 12, 13};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rv1 && rr1) begin
            q1.push_back(res1);
            l1.push_back(rl1);
            if (rl1) last_cyc1 = cyc;
        end
        if (done1) done_cyc1 = cyc;
        if (rv2 && rr2) begin
            q2.push_back(res2);
            l2.push_back(rl2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic feed(input int d, input int npix);
        int n;
        for (int i = 0; i < npix; i++) begin
            if (d == 1) begin pix1 = 8'(i + 1); pv1 = 1'b1; end
            else        begin pix2 = 8'(i + 1); pv2 = 1'b1; end
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!((d == 1) ? pr1 : pr2) && n < 200);
            if (n >= 200) begin
                chk("feed_timeout", 32'(n), 32'(0));
                pv1 = 1'b0;
                pv2 = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        pv1 = 1'b0;
        pv2 = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((d == 1) ? done1 : done2) && n < 200);
        if (n >= 200) chk("done_timeout", 32'(n), 32'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int d, input logic [FW-1:0] f);
        if (d == 1) begin filt1 = f; start1 = 1'b1; end
        else        begin filt2 = f; start2 = 1'b1; end
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
        feed(d, W * H);
        wait_done(d);
    endtask

    task automatic cmp_seq(input string tag, input int d, input int exp[9], input int n);
        logic [ACC_W-1:0] gq[$];
        logic             gl[$];
        if (d == 1) begin gq = q1; gl = l1; end
        else        begin gq = q2; gl = l2; end
        chk({tag, "_count"}, 32'(gq.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < gq.size()) begin
                chk({tag, "_res"}, 32'(gq[i]), 32'(exp[i]) & 32'h001F_FFFF);
                chk({tag, "_last"}, 32'(gl[i]), 32'(i == n - 1));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy1), 32'(0));
        chk("rst_done", 32'(done1), 32'(0));
        chk("rst_rvalid", 32'(rv1), 32'(0));
        chk("rst_rlast", 32'(rl1), 32'(0));
        chk("rst_res", 32'(res1), 32'(0));
        chk("rst_pready", 32'(pr1), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // stride 1, all-ones filter
        q1.delete(); l1.delete();
        run_frame(1, F_ONES);
        cmp_seq("s1", 1, e_s1, 9);
        chk("s1_done_lat", 32'(done_cyc1), 32'(last_cyc1 + 1));
        chk("s1_busy_after", 32'(busy1), 32'(0));

        // stride 2
        q2.delete(); l2.delete();
        run_frame(2, F_ONES);
        cmp_seq("s2", 2, e_s2, 4);
        chk("s2_busy_after", 32'(busy2), 32'(0));

        // coefficient 0 pairs with the top-left pixel
        q1.delete(); l1.delete();
        run_frame(1, F_HOT0);
        cmp_seq("hot0", 1, e_hot, 9);

        // negative filter
        q1.delete(); l1.delete();
        run_frame(1, F_NEG);
        chk("neg_count", 32'(q1.size()), 32'(9));
        if (q1.size() > 0) begin
`ifdef CONV_RELU_EN
            chk("neg_first", 32'(q1[0]), 32'h0000_0000);
`else
            chk("neg_first", 32'(q1[0]), 32'h001F_FFC1);
`endif
        end

        // output backpressure at the first result
        q1.delete(); l1.delete();
        rr1 = 1'b0;
        fork
            run_frame(1, F_ONES);
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!rv1 && n < 200);
                if (n >= 200) chk("bp_timeout", 32'(n), 32'(0));
                for (int i = 0; i < 5; i++) begin
                    chk("bp_hold", 32'(res1), 32'(63));
                    chk("bp_pready", 32'(pr1), 32'(0));
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                rr1 = 1'b1;
            end
        join
        cmp_seq("bp", 1, e_s1, 9);

        // reset mid-frame after 12 pixels, then a clean frame
        start1 = 1'b1;
        filt1 = F_ONES;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        feed(1, 12);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy1), 32'(0));
        chk("mid_rst_rvalid", 32'(rv1), 32'(0));
        chk("mid_rst_pready", 32'(pr1), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q1.delete(); l1.delete();
        run_frame(1, F_ONES);
        cmp_seq("restart", 1, e_s1, 9);

        // start held high with a new filter while busy
        q1.delete(); l1.delete();
        filt1 = F_ONES;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        filt1 = F_TWOS;
        feed(1, W * H);
        start1 = 1'b0;
        wait_done(1);
        cmp_seq("busy_start", 1, e_s1, 9);
        repeat (3) @(negedge clk);
        chk("busy_start_idle", 32'(busy1), 32'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
